multiword_sub_sequencer: RTL and testbench
==========================================

// Module: multiword_sub_sequencer
// PURPOSE
//  Upstream sequencer for ripple_carry_subtractor_32bit.
//  - Accepts one wide operand pair (WORDS x W bits) on a valid/ready handshake.
//  - Feeds the pair to the external combinational subtractor one W-bit word per cycle, LSW first.
//  - Chains the borrow between words, assembles the wide difference, and presents it on a
//    valid/ready output with final borrow and zero flags.
//  - The subtractor is instantiated beside this block in the parent: sub_x/sub_y/sub_b_in drive
//    its X/Y/b_in; its D/b_out return on sub_d/sub_b_out.
// PARAMETERS
//  W      32  word width; must match the subtractor width
//  WORDS  2   words per operand (>=1); total width WORDS*W
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous active-high reset
//  in_valid   in   1        operand pair valid
//  in_ready   out  1        block can accept an operand pair
//  in_a       in   WORDS*W  minuend
//  in_b       in   WORDS*W  subtrahend
//  in_bin     in   1        borrow-in applied to word 0
//  sub_x      out  W        to subtractor X
//  sub_y      out  W        to subtractor Y
//  sub_b_in   out  1        to subtractor b_in
//  sub_d      in   W        from subtractor D
//  sub_b_out  in   1        from subtractor b_out
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  out_d      out  WORDS*W  difference = in_a - in_b - in_bin (mod 2^(WORDS*W))
//  out_borrow out  1        final borrow (1 iff in_a < in_b + in_bin)
//  out_zero   out  1        1 iff out_d == 0
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, idx=0, borrow_r=0, operand/result regs=0,
//    out_valid=0, out_borrow=0, out_zero=0. in_ready=1 once reset is deasserted.
//  - The subtractor is assumed purely combinational: it returns sub_d/sub_b_out in the same
//    cycle as sub_x/sub_y/sub_b_in.
//  - FSM states: IDLE, RUN, DONE. Encoding lives in the package.
//  - IDLE:
//    - in_ready=1.
//    - On in_valid: latch a_r<=in_a, b_r<=in_b, borrow_r<=in_bin, idx<=0; go to RUN.
//    - sub_x/sub_y/sub_b_in are driven to 0.
//  - RUN:
//    - sub_x=a_r[idx*W +: W], sub_y=b_r[idx*W +: W], sub_b_in=borrow_r.
//    - Each clock: d_r[idx*W +: W]<=sub_d, borrow_r<=sub_b_out, idx<=idx+1.
//    - When idx==WORDS-1: go to DONE instead of incrementing.
//    - in_ready=0; in_valid is ignored.
//  - DONE:
//    - out_valid=1; out_d=d_r; out_borrow=borrow_r; out_zero=(d_r==0).
//    - Outputs are held stable until out_ready.
//    - On out_ready: go to IDLE. out_valid drops on the next cycle.
//    - in_ready=0, so no accept in the same cycle as the output handshake.
//  - Latency: out_valid rises exactly WORDS cycles after the accepting edge.
//  - Throughput: one operation per WORDS+2 cycles with out_ready held at 1.
//  - Width rules:
//    - idx is clog2(WORDS) bits wide, minimum 1.
//    - Arithmetic is modulo 2^(WORDS*W); no saturation.
//  - Boundaries:
//    - WORDS=1: RUN lasts one cycle.
//    - in_valid held high during RUN/DONE: no second capture.
//    - out_ready high before DONE: no effect.
//    - rst mid-RUN: the partial result is discarded and out_valid never pulses.
//    - Borrow-out of the last word goes only to out_borrow and never wraps to word 0.
// STRUCTURE
//  - Package sub_pkg holds: W default, the state typedef/localparams
//    (IDLE=2'd0, RUN=2'd1, DONE=2'd2), and a clog2 helper.
//  - Single module, no sub-module. The word mux and result write stay inline.
//  - The subtractor stays outside this block; the parent or bench instantiates
//    ripple_carry_subtractor_32bit.
// TESTING (WORDS=2, W=32, real ripple_carry_subtractor_32bit wired on sub_*)
//  1. Basic:
//     - Stimulus: in_a=0x7, in_b=0x5, in_bin=0.
//     - Required: out_d=0x2, out_borrow=0, out_zero=0; out_valid rises 2 cycles after accept.
//  2. Borrow-in:
//     - Stimulus: in_a=0x101, in_b=0x17, in_bin=1.
//     - Required: out_d=0xE9, out_borrow=0.
//  3. Cross-word borrow:
//     - Stimulus: in_a=0x1_0000_0000, in_b=0x1, in_bin=0.
//     - Required: out_d=0x0000_0000_FFFF_FFFF, out_borrow=0.
//  4. Underflow/zero:
//     - Stimulus: in_a=0, in_b=1, in_bin=0.
//     - Required: out_d=all 1s, out_borrow=1.
//     - Then: in_a=in_b=0x5 -> out_d=0, out_zero=1.
//  5. Backpressure:
//     - Stimulus: hold out_ready=0 for 5 cycles in DONE, with in_valid=1 throughout.
//     - Required: out_d stable; in_ready=0; exactly one accept after the output handshake.
//  6. Reset mid-run:
//     - Stimulus: assert rst during RUN (idx=1).
//     - Required: out_valid=0 and in_ready=1 after deassert; the next op (7-5) returns 0x2.

Source files
------------

// File: rtl/sub_pkg.sv
// +----------------------------------------------------------------------------+
// | Module  : sub_pkg                                                          |
// | Brief   : Shared width default, sequencer state encoding and clog2 helper. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package sub_pkg;

    localparam int SUB_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width never drops below one bit, even for a single-word operand.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ripple_carry_subtractor_32bit.sv
// +----------------------------------------------------------------------------+
// | Module  : ripple_carry_subtractor_32bit                                    |
// | Brief   : Combinational 32-bit subtractor D = X - Y - b_in with borrow out.|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module ripple_carry_subtractor_32bit (
    input  logic [31:0] X,
    input  logic [31:0] Y,
    input  logic        b_in,
    output logic [31:0] D,
    output logic        b_out
);

    logic [32:0] w_borrow;

    always_comb begin
        D        = '0;
        w_borrow = '0;
        w_borrow[0] = b_in;
        for (int i = 0; i < 32; i++) begin
            D[i]          = X[i] ^ Y[i] ^ w_borrow[i];
            w_borrow[i+1] = (~X[i] & Y[i]) | (~(X[i] ^ Y[i]) & w_borrow[i]);
        end
    end

    assign b_out = w_borrow[32];

endmodule

`default_nettype wire

// File: rtl/multiword_sub_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : multiword_sub_sequencer                                          |
// | Brief   : Walks a WORDS x W operand pair through an external W-bit         |
// |           subtractor LSW first, chaining borrow, and returns the result.   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module multiword_sub_sequencer
    import sub_pkg::*;
#(
    parameter int W     = SUB_W,
    parameter int WORDS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORDS*W-1:0] in_a,
    input  logic [WORDS*W-1:0] in_b,
    input  logic               in_bin,
    output logic [W-1:0]       sub_x,
    output logic [W-1:0]       sub_y,
    output logic               sub_b_in,
    input  logic [W-1:0]       sub_d,
    input  logic               sub_b_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WORDS*W-1:0] out_d,
    output logic               out_borrow,
    output logic               out_zero
);

    localparam int c_TOT_W = WORDS * W;
    localparam int c_IDX_W = clog2_min1(WORDS);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WORDS - 1);

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic                 r_borrow;
    logic [c_TOT_W-1:0]   r_a;
    logic [c_TOT_W-1:0]   r_b;
    logic [c_TOT_W-1:0]   r_d;
    logic                 r_out_valid;
    logic                 r_out_borrow;
    logic                 r_out_zero;

    int                   w_base;
    logic [c_TOT_W-1:0]   w_d_next;
    logic                 w_last;

    assign w_base = int'(r_idx) * W;
    assign w_last = (r_idx == c_LAST_IDX);

    // Subtractor inputs are parked at zero outside RUN so it sees no toggling.
    always_comb begin
        sub_x    = '0;
        sub_y    = '0;
        sub_b_in = 1'b0;
        w_d_next = r_d;
        if (r_state == RUN) begin
            sub_x    = r_a[w_base +: W];
            sub_y    = r_b[w_base +: W];
            sub_b_in = r_borrow;
            w_d_next[w_base +: W] = sub_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_borrow     <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_d          <= '0;
            r_out_valid  <= 1'b0;
            r_out_borrow <= 1'b0;
            r_out_zero   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_borrow <= in_bin;
                        r_idx    <= '0;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_d      <= w_d_next;
                    r_borrow <= sub_b_out;
                    // Final borrow lands only in the result flags, never back on word 0.
                    if (w_last) begin
                        r_state      <= DONE;
                        r_out_valid  <= 1'b1;
                        r_out_borrow <= sub_b_out;
                        r_out_zero   <= (w_d_next == '0);
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state      <= IDLE;
                        r_out_valid  <= 1'b0;
                        r_out_borrow <= 1'b0;
                        r_out_zero   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == IDLE) && !rst;
    assign out_valid  = r_out_valid;
    assign out_d      = r_d;
    assign out_borrow = r_out_borrow;
    assign out_zero   = r_out_zero;

endmodule

`default_nettype wire

// File: tb/tb_multiword_sub_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_multiword_sub_sequencer                                       |
// | Brief   : Scoreboard bench for the sequencer wired to the 32-bit subtractor|
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_multiword_sub_sequencer;

    localparam int W     = 32;
    localparam int WORDS = 2;
    localparam int TW    = W * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] in_a;
    logic [TW-1:0] in_b;
    logic          in_bin;
    logic [W-1:0]  sub_x;
    logic [W-1:0]  sub_y;
    logic          sub_b_in;
    logic [W-1:0]  sub_d;
    logic          sub_b_out;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] out_d;
    logic          out_borrow;
    logic          out_zero;

    typedef struct {
        logic [TW-1:0] d;
        logic          borrow;
        logic          zero;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   accept_cycle = 0;
    int   n_accept = 0;
    int   base_accept = 0;
    logic prev_out_valid = 1'b0;

    multiword_sub_sequencer #(.W(W), .WORDS(WORDS)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_bin    (in_bin),
        .sub_x     (sub_x),
        .sub_y     (sub_y),
        .sub_b_in  (sub_b_in),
        .sub_d     (sub_d),
        .sub_b_out (sub_b_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_d     (out_d),
        .out_borrow(out_borrow),
        .out_zero  (out_zero)
    );

    ripple_carry_subtractor_32bit u_sub (
        .X    (sub_x),
        .Y    (sub_y),
        .b_in (sub_b_in),
        .D    (sub_d),
        .b_out(sub_b_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic exp_t model(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic bin);
        exp_t        e;
        logic [TW:0] full;
        full     = {1'b0, a} - {1'b0, b} - (TW + 1)'(bin);
        e.d      = full[TW-1:0];
        e.borrow = full[TW];
        e.zero   = (full[TW-1:0] == '0);
        return e;
    endfunction

    // Inputs change only #1 after posedge, so negedge sees exactly what the next edge will.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) begin
            sb.push_back(model(in_a, in_b, in_bin));
            n_accept++;
            accept_cycle = cyc + 1;
        end
        if (!rst && out_valid) begin
            if (!prev_out_valid) check_val("latency", 128'(cyc - accept_cycle), 128'(WORDS));
            check_val("in_ready_done", in_ready, 1'b0);
            if (sb.size() == 0) begin
                check_val("unexpected_out", 1'b1, 1'b0);
            end else if (out_ready) begin
                mon_e = sb.pop_front();
                check_val("out_d", out_d, mon_e.d);
                check_val("out_borrow", out_borrow, mon_e.borrow);
                check_val("out_zero", out_zero, mon_e.zero);
            end else begin
                check_val("hold_d", out_d, sb[0].d);
                check_val("hold_borrow", out_borrow, sb[0].borrow);
            end
        end
        prev_out_valid = out_valid;
    end

    task automatic send(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic bin, input bit hold);
        int budget;
        bit got;
        budget   = 0;
        got      = 1'b0;
        in_a     = a;
        in_b     = b;
        in_bin   = bin;
        in_valid = 1'b1;
        while (!got && budget < 50) begin
            @(negedge clk);
            got = in_ready && !rst;
            @(posedge clk);
            #1;
            budget++;
        end
        if (!got) check_val("accept_timeout", 1'b0, 1'b1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((sb.size() != 0 || out_valid) && budget < 100) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (budget >= 100) begin
            check_val("drain_timeout", 1'b0, 1'b1);
            sb.delete();
        end
    endtask

    initial begin
        int budget;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_bin    = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_borrow", out_borrow, 1'b0);
        check_val("rst_out_zero", out_zero, 1'b0);
        check_val("rst_out_d", out_d, 64'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("rst_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        send(64'h7, 64'h5, 1'b0, 1'b0);                    wait_drain();
        send(64'h101, 64'h17, 1'b1, 1'b0);                 wait_drain();
        send(64'h1_0000_0000, 64'h1, 1'b0, 1'b0);          wait_drain();
        send(64'h0, 64'h1, 1'b0, 1'b0);                    wait_drain();
        send(64'h5, 64'h5, 1'b0, 1'b0);                    wait_drain();
        send(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);  wait_drain();
        for (int i = 0; i < 6; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
            wait_drain();
        end

        // Backpressure with in_valid held high throughout
        out_ready   = 1'b0;
        base_accept = n_accept;
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_F000_0000, 1'b0, 1'b1);
        budget = 0;
        while (!out_valid && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!out_valid) check_val("bp_valid_timeout", 1'b0, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check_val("bp_accepts_held", 128'(n_accept - base_accept), 128'd1);
        out_ready = 1'b1;
        budget = 0;
        while (n_accept < base_accept + 2 && budget < 20) begin
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        wait_drain();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check_val("bp_accepts_total", 128'(n_accept - base_accept), 128'd2);

        // Reset during the second RUN cycle
        send(64'hDEAD_BEEF_0000_0001, 64'h0000_1234_0000_0002, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check_val("midrst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_val("midrst_in_ready", in_ready, 1'b1);
        check_val("midrst_valid_after", out_valid, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        send(64'h7, 64'h5, 1'b0, 1'b0);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
